// File: rtl/y86_pkg.sv
// Shared Y86-64 decode definitions: icode constants, register IDs, decode helpers.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package y86_pkg;

  localparam int NREG = 15;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RSP   = 4'h4;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  // Register IDs selected for one instruction, plus the invalid-icode flag.
  typedef struct packed {
    logic [3:0] src_a;
    logic [3:0] src_b;
    logic [3:0] dst_e;
    logic [3:0] dst_m;
    logic       err;
  } dec_t;

  // Everything handed to execute in one beat.
  typedef struct packed {
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] val_c;
    logic [63:0] val_p;
    dec_t        ids;
    logic [63:0] val_a;
    logic [63:0] val_b;
  } bundle_t;

  // Invalid icodes decode to all-RNONE so they never touch the register file.
  function automatic dec_t decode_ids(input logic [3:0] icode,
                                      input logic [3:0] ra,
                                      input logic [3:0] rb);
    dec_t d;
    d.src_a = RNONE;
    d.src_b = RNONE;
    d.dst_e = RNONE;
    d.dst_m = RNONE;
    d.err   = (icode > IPOPQ);
    case (icode)
      IRRMOVQ: begin d.src_a = ra;  d.dst_e = rb; end
      IIRMOVQ: begin d.dst_e = rb; end
      IRMMOVQ: begin d.src_a = ra;  d.src_b = rb; end
      IMRMOVQ: begin d.src_b = rb;  d.dst_m = ra; end
      IOPQ:    begin d.src_a = ra;  d.src_b = rb; d.dst_e = rb; end
      ICALL:   begin d.src_b = RSP; d.dst_e = RSP; end
      IRET:    begin d.src_a = RSP; d.src_b = RSP; d.dst_e = RSP; end
      IPUSHQ:  begin d.src_a = ra;  d.src_b = RSP; d.dst_e = RSP; end
      IPOPQ:   begin d.src_a = RSP; d.src_b = RSP; d.dst_e = RSP; d.dst_m = ra; end
      default: ;
    endcase
    return d;
  endfunction

  // Same-cycle writeback bypass for one read port; valM beats valE like the regfile.
  function automatic logic [63:0] wb_bypass(input logic [3:0]  id,
                                            input logic [63:0] rf_val,
                                            input logic        en,
                                            input logic [3:0]  dst_e,
                                            input logic [63:0] val_e,
                                            input logic [3:0]  dst_m,
                                            input logic [63:0] val_m);
    logic [63:0] v;
    v = rf_val;
    if (en && id != RNONE) begin
      if (dst_m == id)      v = val_m;
      else if (dst_e == id) v = val_e;
    end
    return v;
  endfunction

  // Reset image of the output bundle: zero data, all IDs RNONE.
  function automatic bundle_t bundle_reset();
    bundle_t b;
    b           = '0;
    b.ids.src_a = RNONE;
    b.ids.src_b = RNONE;
    b.ids.dst_e = RNONE;
    b.ids.dst_m = RNONE;
    return b;
  endfunction

endpackage

// File: rtl/decode_wb_if.sv
// Fetch-side input bundle and execute-side decoded bundle with valid/ready.
// Latency: n/a (wiring only).
// Backpressure: in_ready/out_ready carry the handshake in each direction.
interface decode_wb_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic [3:0]  rA;
  logic [3:0]  rB;
  logic [63:0] valC;
  logic [63:0] valP;

  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_icode;
  logic [3:0]  out_ifun;
  logic [63:0] out_valC;
  logic [63:0] out_valP;
  logic [3:0]  srcA;
  logic [3:0]  srcB;
  logic [3:0]  dstE;
  logic [3:0]  dstM;
  logic [63:0] valA;
  logic [63:0] valB;
  logic        out_err;

  // Decode stage side.
  modport slave (
    input  in_valid, icode, ifun, rA, rB, valC, valP, out_ready,
    output in_ready, out_valid, out_icode, out_ifun, out_valC, out_valP,
           srcA, srcB, dstE, dstM, valA, valB, out_err
  );

  // Fetch/execute side driving the decode stage.
  modport master (
    output in_valid, icode, ifun, rA, rB, valC, valP, out_ready,
    input  in_ready, out_valid, out_icode, out_ifun, out_valC, out_valP,
           srcA, srcB, dstE, dstM, valA, valB, out_err
  );
endinterface

// File: rtl/y86_regfile.sv
// 15 x 64-bit register file, IDs 0..14; ID 15 (RNONE) reads 0 and ignores writes.
// Latency: reads combinational, writes land on the rising edge.
// Backpressure: none; a write is always accepted.
module y86_regfile
  import y86_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  rd_a_id,
  output logic [63:0] rd_a_val,
  input  logic [3:0]  rd_b_id,
  output logic [63:0] rd_b_val,
  input  logic        wr_en,
  input  logic [3:0]  wr_e_id,
  input  logic [63:0] wr_e_val,
  input  logic [3:0]  wr_m_id,
  input  logic [63:0] wr_m_val
);

  logic [63:0] regs [NREG];

  assign rd_a_val = (rd_a_id == RNONE) ? 64'd0 : regs[rd_a_id];
  assign rd_b_val = (rd_b_id == RNONE) ? 64'd0 : regs[rd_b_id];

  // Dual write; when both ports hit one register the M port wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NREG; i++) begin
        if (wr_m_id == 4'(i))      regs[i] <= wr_m_val;
        else if (wr_e_id == 4'(i)) regs[i] <= wr_e_val;
      end
    end
  end

endmodule

// File: rtl/decode_wb.sv
// Y86 decode + writeback stage: decodes register IDs, reads regfile, registers the bundle.
// Latency: 1 cycle from capture to out_valid; optional DECODE_WB_FWD_EN bypasses same-cycle writeback.
// Backpressure: in_ready = !out_valid || out_ready; the output bundle holds while stalled.
module decode_wb
  import y86_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  decode_wb_if.slave  bus,
  input  logic        wb_en,
  input  logic [3:0]  wb_dstE,
  input  logic [3:0]  wb_dstM,
  input  logic [63:0] wb_valE,
  input  logic [63:0] wb_valM
);

  dec_t        dec;
  logic [63:0] rf_a;
  logic [63:0] rf_b;
  logic [63:0] rd_a;
  logic [63:0] rd_b;
  logic        capture;
  logic        out_valid_q;
  bundle_t     out_q;

  assign dec     = decode_ids(bus.icode, bus.rA, bus.rB);
  assign capture = bus.in_valid && bus.in_ready;

  y86_regfile u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_a_id  (dec.src_a),
    .rd_a_val (rf_a),
    .rd_b_id  (dec.src_b),
    .rd_b_val (rf_b),
    .wr_en    (wb_en),
    .wr_e_id  (wb_dstE),
    .wr_e_val (wb_valE),
    .wr_m_id  (wb_dstM),
    .wr_m_val (wb_valM)
  );

`ifdef DECODE_WB_FWD_EN
  assign rd_a = wb_bypass(dec.src_a, rf_a, wb_en, wb_dstE, wb_valE, wb_dstM, wb_valM);
  assign rd_b = wb_bypass(dec.src_b, rf_b, wb_en, wb_dstE, wb_valE, wb_dstM, wb_valM);
`else
  // Without bypass a read racing a write sees the pre-write value.
  assign rd_a = rf_a;
  assign rd_b = rf_b;
`endif

  // Output stage: load on capture, drop valid once consumed, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_q       <= bundle_reset();
    end else if (capture) begin
      out_valid_q <= 1'b1;
      out_q.icode <= bus.icode;
      out_q.ifun  <= bus.ifun;
      out_q.val_c <= bus.valC;
      out_q.val_p <= bus.valP;
      out_q.ids   <= dec;
      out_q.val_a <= rd_a;
      out_q.val_b <= rd_b;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = !out_valid_q || bus.out_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_icode = out_q.icode;
  assign bus.out_ifun  = out_q.ifun;
  assign bus.out_valC  = out_q.val_c;
  assign bus.out_valP  = out_q.val_p;
  assign bus.srcA      = out_q.ids.src_a;
  assign bus.srcB      = out_q.ids.src_b;
  assign bus.dstE      = out_q.ids.dst_e;
  assign bus.dstM      = out_q.ids.dst_m;
  assign bus.valA      = out_q.val_a;
  assign bus.valB      = out_q.val_b;
  assign bus.out_err   = out_q.ids.err;

endmodule

// File: tb/tb_decode_wb.sv
// Bench for decode_wb: directed bundles, expected results queued, monitor compares on handshake.
// Latency: checks one-cycle capture-to-valid and hold under stall.
// Backpressure: exercises out_ready=0 stalls; DECODE_WB_FWD_EN selects expected bypass values.
module tb_decode_wb;

  typedef struct packed {
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] valc;
    logic [63:0] valp;
    logic [3:0]  srca;
    logic [3:0]  srcb;
    logic [3:0]  dste;
    logic [3:0]  dstm;
    logic [63:0] vala;
    logic [63:0] valb;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_en;
  logic [3:0]  wb_dstE;
  logic [3:0]  wb_dstM;
  logic [63:0] wb_valE;
  logic [63:0] wb_valM;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   beats    = 0;

  decode_wb_if bus();

  decode_wb dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .wb_en   (wb_en),
    .wb_dstE (wb_dstE),
    .wb_dstM (wb_dstM),
    .wb_valE (wb_valE),
    .wb_valM (wb_valM)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic expect_b(input logic [3:0] ic, input logic [3:0] fn,
                          input logic [63:0] vc, input logic [63:0] vp,
                          input logic [3:0] sa, input logic [3:0] sb,
                          input logic [3:0] de, input logic [3:0] dm,
                          input logic [63:0] va, input logic [63:0] vb,
                          input logic er);
    exp_t e;
    e.icode = ic; e.ifun = fn; e.valc = vc; e.valp = vp;
    e.srca = sa; e.srcb = sb; e.dste = de; e.dstm = dm;
    e.vala = va; e.valb = vb; e.err = er;
    q.push_back(e);
  endtask

  task automatic drive_in(input logic [3:0] ic, input logic [3:0] fn,
                          input logic [3:0] a, input logic [3:0] b,
                          input logic [63:0] c, input logic [63:0] p);
    bus.in_valid = 1'b1;
    bus.icode = ic; bus.ifun = fn; bus.rA = a; bus.rB = b;
    bus.valC = c; bus.valP = p;
  endtask

  // Present a bundle, wait (bounded) for in_ready, then check one-cycle latency.
  task automatic issue(input logic [3:0] ic, input logic [3:0] fn,
                       input logic [3:0] a, input logic [3:0] b,
                       input logic [63:0] c, input logic [63:0] p);
    int n = 0;
    drive_in(ic, fn, a, b, c, p);
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("in_ready_wait", 64'(n < 50), 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("lat_out_valid", 64'(bus.out_valid), 64'd1);
    chk("lat_out_icode", 64'(bus.out_icode), 64'(ic));
  endtask

  task automatic wb(input logic [3:0] de, input logic [3:0] dm,
                    input logic [63:0] ve, input logic [63:0] vm);
    wb_en = 1'b1; wb_dstE = de; wb_dstM = dm; wb_valE = ve; wb_valM = vm;
    @(posedge clk);
    #1;
    wb_en = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (q.size() != 0 && w < 100) begin
      w++;
      @(posedge clk);
    end
    #1;
    chk("scoreboard_drained", 64'(q.size()), 64'd0);
  endtask

  // Monitor: a beat transfers when valid and ready are both high at the coming edge.
  initial begin
    forever begin : mon
      exp_t a;
      exp_t e;
      @(negedge clk);
      if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        a.icode = bus.out_icode; a.ifun = bus.out_ifun;
        a.valc = bus.out_valC; a.valp = bus.out_valP;
        a.srca = bus.srcA; a.srcb = bus.srcB; a.dste = bus.dstE; a.dstm = bus.dstM;
        a.vala = bus.valA; a.valb = bus.valB; a.err = bus.out_err;
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL beat%0d unexpected bundle actual icode=%h required none", beats, a.icode);
        end else begin
          e = q.pop_front();
          if (a !== e) begin
            failures++;
            $display("FAIL beat%0d actual icode=%h ifun=%h valC=%h valP=%h src=%h/%h dst=%h/%h valA=%h valB=%h err=%b required icode=%h ifun=%h valC=%h valP=%h src=%h/%h dst=%h/%h valA=%h valB=%h err=%b",
                     beats, a.icode, a.ifun, a.valc, a.valp, a.srca, a.srcb, a.dste, a.dstm, a.vala, a.valb, a.err,
                     e.icode, e.ifun, e.valc, e.valp, e.srca, e.srcb, e.dste, e.dstm, e.vala, e.valb, e.err);
          end
        end
        beats++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    wb_en = 1'b0; wb_dstE = 4'hF; wb_dstM = 4'hF; wb_valE = '0; wb_valM = '0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.icode = '0; bus.ifun = '0; bus.rA = '0; bus.rB = '0; bus.valC = '0; bus.valP = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_err",   64'(bus.out_err),   64'd0);
    chk("rst_srcA",      64'(bus.srcA),      64'hF);
    chk("rst_dstM",      64'(bus.dstM),      64'hF);
    chk("rst_valB",      bus.valB,           64'd0);
    chk("rst_out_valP",  bus.out_valP,       64'd0);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Write r3 then OPq r3,r3.
    wb(4'h3, 4'hF, 64'h1234, 64'h0);
    expect_b(4'h6, 4'h0, 64'h0, 64'h100, 4'h3, 4'h3, 4'h3, 4'hF, 64'h1234, 64'h1234, 1'b0);
    issue(4'h6, 4'h0, 4'h3, 4'h3, 64'h0, 64'h100);

    // Stall: first bundle held, second waits for out_ready.
    drain();
    bus.out_ready = 1'b0;
    expect_b(4'h3, 4'h0, 64'hAAAA, 64'h10, 4'hF, 4'hF, 4'h2, 4'hF, 64'h0, 64'h0, 1'b0);
    issue(4'h3, 4'h0, 4'hF, 4'h2, 64'hAAAA, 64'h10);
    expect_b(4'h1, 4'h0, 64'h0, 64'h20, 4'hF, 4'hF, 4'hF, 4'hF, 64'h0, 64'h0, 1'b0);
    drive_in(4'h1, 4'h0, 4'h3, 4'h3, 64'h0, 64'h20);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready",  64'(bus.in_ready),  64'd0);
      chk("stall_out_valid", 64'(bus.out_valid), 64'd1);
      chk("stall_out_valC",  bus.out_valC,       64'hAAAA);
      chk("stall_dstE",      64'(bus.dstE),      64'h2);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("second_captured", 64'(bus.out_icode), 64'h1);
    chk("second_valP",     bus.out_valP,       64'h20);

    // Same-ID writeback: valM wins, then popq reads it.
    wb(4'h4, 4'h4, 64'h8, 64'h10);
    expect_b(4'hB, 4'h0, 64'h0, 64'h202, 4'h4, 4'h4, 4'h4, 4'h7, 64'h10, 64'h10, 1'b0);
    issue(4'hB, 4'h0, 4'h7, 4'hF, 64'h0, 64'h202);

    // Distinct IDs on both write ports, then the remaining icode classes.
    wb(4'h6, 4'h7, 64'h1, 64'h2);
    expect_b(4'h6, 4'h1, 64'h0, 64'h302, 4'h6, 4'h7, 4'h7, 4'hF, 64'h1, 64'h2, 1'b0);
    issue(4'h6, 4'h1, 4'h6, 4'h7, 64'h0, 64'h302);
    expect_b(4'h8, 4'h0, 64'h400, 64'h309, 4'hF, 4'h4, 4'h4, 4'hF, 64'h0, 64'h10, 1'b0);
    issue(4'h8, 4'h0, 4'hF, 4'hF, 64'h400, 64'h309);
    expect_b(4'hA, 4'h0, 64'h0, 64'h30B, 4'h3, 4'h4, 4'h4, 4'hF, 64'h1234, 64'h10, 1'b0);
    issue(4'hA, 4'h0, 4'h3, 4'hF, 64'h0, 64'h30B);
    expect_b(4'h9, 4'h0, 64'h0, 64'h30C, 4'h4, 4'h4, 4'h4, 4'hF, 64'h10, 64'h10, 1'b0);
    issue(4'h9, 4'h0, 4'hF, 4'hF, 64'h0, 64'h30C);
    expect_b(4'h5, 4'h0, 64'h8, 64'h316, 4'hF, 4'h6, 4'hF, 4'h8, 64'h0, 64'h1, 1'b0);
    issue(4'h5, 4'h0, 4'h8, 4'h6, 64'h8, 64'h316);
    expect_b(4'h7, 4'h2, 64'h500, 64'h31F, 4'hF, 4'hF, 4'hF, 4'hF, 64'h0, 64'h0, 1'b0);
    issue(4'h7, 4'h2, 4'h3, 4'h3, 64'h500, 64'h31F);
    expect_b(4'h0, 4'h0, 64'h0, 64'h320, 4'hF, 4'hF, 4'hF, 4'hF, 64'h0, 64'h0, 1'b0);
    issue(4'h0, 4'h0, 4'h3, 4'h3, 64'h0, 64'h320);
    expect_b(4'hE, 4'h3, 64'hDEAD, 64'hBEEF, 4'hF, 4'hF, 4'hF, 4'hF, 64'h0, 64'h0, 1'b1);
    issue(4'hE, 4'h3, 4'h1, 4'h2, 64'hDEAD, 64'hBEEF);

    // Writeback to r5 in the capture cycle of a read of r5.
    wb(4'h5, 4'hF, 64'h55, 64'h0);
`ifdef DECODE_WB_FWD_EN
    expect_b(4'h2, 4'h0, 64'h0, 64'h402, 4'h5, 4'hF, 4'h1, 4'hF, 64'h66, 64'h0, 1'b0);
`else
    expect_b(4'h2, 4'h0, 64'h0, 64'h402, 4'h5, 4'hF, 4'h1, 4'hF, 64'h55, 64'h0, 1'b0);
`endif
    drive_in(4'h2, 4'h0, 4'h5, 4'h1, 64'h0, 64'h402);
    wb_en = 1'b1; wb_dstE = 4'h5; wb_dstM = 4'hF; wb_valE = 64'h66; wb_valM = 64'h0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    wb_en = 1'b0;
    chk("fwd_lat_valid", 64'(bus.out_valid), 64'd1);
    expect_b(4'h4, 4'h0, 64'h18, 64'h40C, 4'h5, 4'h5, 4'hF, 4'hF, 64'h66, 64'h66, 1'b0);
    issue(4'h4, 4'h0, 4'h5, 4'h5, 64'h18, 64'h40C);

    // Reset during a stalled bundle with a writeback pending.
    drain();
    bus.out_ready = 1'b0;
    issue(4'h6, 4'h0, 4'h3, 4'h3, 64'h0, 64'h500);
    wb_en = 1'b1; wb_dstE = 4'h3; wb_dstM = 4'hF; wb_valE = 64'h77;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_in_ready",  64'(bus.in_ready),  64'd1);
    chk("midrst_srcA",      64'(bus.srcA),      64'hF);
    chk("midrst_valA",      bus.valA,           64'd0);
    @(posedge clk);
    #1;
    wb_en = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    expect_b(4'h6, 4'h0, 64'h0, 64'h600, 4'h3, 4'h3, 4'h3, 4'hF, 64'h0, 64'h0, 1'b0);
    issue(4'h6, 4'h0, 4'h3, 4'h3, 64'h0, 64'h600);

    drain();
    chk("beats_seen", 64'(beats), 64'd15);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_wb.md
DECODE_WB -- requirements
Module: decode_wb

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port in_valid  input  1  fetch-side bundle valid.
REQ-004 SHALL have port in_ready  output  1  decode can accept the bundle this cycle.
REQ-005 SHALL have ports icode, ifun, rA, rB  input  4 each  fetched instruction fields.
REQ-006 SHALL have ports valC, valP  input  64 each  fetched constant and next PC; passed through.
REQ-007 SHALL have port out_valid  output  1  decoded bundle valid toward execute.
REQ-008 SHALL have port out_ready  input  1  execute accepts the bundle.
REQ-009 SHALL have ports out_icode, out_ifun  output  4 each; out_valC, out_valP  output  64 each  registered copies of the inputs.
REQ-010 SHALL have ports srcA, srcB, dstE, dstM  output  4 each  decoded register IDs; 4'hF = RNONE.
REQ-011 SHALL have ports valA, valB  output  64 each  register-file read data.
REQ-012 SHALL have port out_err  output  1  icode > 4'hB (invalid instruction).
REQ-013 SHALL have ports wb_en  input  1; wb_dstE, wb_dstM  input  4 each; wb_valE, wb_valM  input  64 each  writeback request.

Function
REQ-014 SHALL hold a 15 x 64-bit register file, IDs 0..14; reading RNONE returns 0; a write to RNONE is ignored.
REQ-015 SHALL decode srcA: rA for icode 2,4,6,A; RSP (4) for 9,B; else RNONE.
REQ-016 SHALL decode srcB: rB for icode 4,5,6; RSP for 8,9,A,B; else RNONE.
REQ-017 SHALL decode dstE: rB for icode 2,3,6; RSP for 8,9,A,B; else RNONE. dstM: rA for icode 5,B; else RNONE.
REQ-018 SHALL drive in_ready = !out_valid || out_ready, combinationally.
REQ-019 SHALL capture on in_valid && in_ready; all out_* fields, srcA/srcB/dstE/dstM, valA/valB and out_valid=1 are registered next edge (latency 1 cycle).
REQ-020 SHALL clear out_valid when out_ready=1 and there is no capture that cycle; outputs SHALL hold stable while out_valid && !out_ready.
REQ-021 SHALL write wb_valE to wb_dstE and wb_valM to wb_dstM on a wb_en edge; if both target the same ID, valM SHALL win.
REQ-022 SHALL set out_err=1 for icode 4'hC..4'hF, with all four IDs RNONE and valA=valB=0; the bundle still passes through.
REQ-023 SHALL NOT stall on halt (icode 0); it decodes as all-RNONE and passes through.
REQ-024 SHALL ignore valC/valP for decode; they are pass-through only.

Reset
REQ-025 SHALL on rst_n=0 clear immediately: out_valid=0, out_err=0, all out_* and valA/valB to 0, all four IDs to RNONE, all 15 registers to 0.
REQ-026 SHALL discard any held bundle and any same-cycle writeback when reset asserts mid-operation; no register write occurs during reset.

Configuration
REQ-027 SHALL, with DECODE_WB_FWD_EN defined, bypass a same-cycle writeback to a read of the same ID at capture (valM priority over valE); without it, the read returns the pre-write register value.

Structure
REQ-028 SHALL take icode constants (IHALT..IPOPQ), RNONE=4'hF and RSP=4'h4 from shared package y86_pkg.
REQ-029 SHALL instantiate sub-module y86_regfile: 2 asynchronous read ports, 2 write ports with the REQ-021 priority, async active-low reset.

Verification
REQ-030 SHALL verify: reset, then wb_en with dstE=3 and valE=64'h1234, then OPq icode 6 with rA=3 and rB=3 -> valA=valB=64'h1234, dstE=3, one cycle after capture.
REQ-031 SHALL verify: out_ready=0 with two back-to-back in_valid bundles -> the first bundle is held stable, in_ready=0, and the second is captured only after out_ready=1.
REQ-032 SHALL verify: wb_en with dstE=dstM=4, valE=8 and valM=16 -> a subsequent popq icode B reads valA=16; dstE=4 and dstM=rA.
REQ-033 SHALL verify: wb to register 5 in the same cycle as a capture reading register 5 -> new value with DECODE_WB_FWD_EN, old value without it.
REQ-034 SHALL verify: icode 4'hE -> out_err=1, all IDs 4'hF, valA=valB=0.
REQ-035 SHALL verify: rst_n pulled low while out_valid=1 and out_ready=0 -> out_valid=0 immediately, and register 3 reads 0 afterward.
